// File: rtl/wb_ram_slave.sv
// Wishbone-style single-port RAM slave with wait states, an out-of-range error flag and a cycle counter.
// Latency: WAIT_CYCLES+1 cycles from wb_cyc_i sampled high to wb_ack_o; back-to-back transfers take WAIT_CYCLES+2 cycles.
// Backpressure: none towards the master; dropping wb_cyc_i during the wait phase aborts the transfer with no write and no ack.
//
// Ports:
//   clk, resetn             - system clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i    - word address [31:2], write data, byte enables (bit n = lane n)
//   wb_we_i, wb_cyc_i       - write strobe, bus request
//   wb_rdt_o, wb_ack_o      - read data (non-zero only in the ack cycle), one-cycle acknowledge
//   err_o                   - sticky out-of-range access flag
//   cycle_cnt_o             - saturating cycle count since reset release, frozen once done_o is set
//   done_o, done_code_o     - end-of-test mailbox outputs
//
// Build option: define WB_RAM_MAILBOX_EN to decode word address 30'h0400_0001 as the
// end-of-test mailbox. Without it that address is an ordinary out-of-range access and
// done_o / done_code_o are tied to zero.

module wb_ram_slave #(
   parameter int DEPTH       = 4096,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [29:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   output logic [31:0] wb_rdt_o,
   output logic        wb_ack_o,
   output logic        err_o,
   output logic [31:0] cycle_cnt_o,
   output logic        done_o,
   output logic [7:0]  done_code_o
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
   localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;

   // Request captured in IDLE; the bus inputs are not looked at again except wb_cyc_i.
   logic [29:0] adr_q;
   logic [31:0] dat_q;
   logic [3:0]  sel_q;
   logic        we_q;

   logic [31:0] mem [DEPTH];

   logic [AW-1:0] idx;
   logic          in_range;
   logic          is_mbox;
   logic          mem_we;

   assign idx      = adr_q[AW-1:0];
   assign in_range = (adr_q < DEPTH_W);

`ifdef WB_RAM_MAILBOX_EN
   localparam logic [29:0] MBOX_ADR = 30'h0400_0001;
   assign is_mbox = (adr_q == MBOX_ADR);
`else
   assign is_mbox = 1'b0;
`endif

   // The mailbox takes precedence over RAM so a very large DEPTH cannot shadow it.
   assign mem_we = (state == ACK) && we_q && in_range && !is_mbox;

   // RAM array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) begin
               mem[idx][8*b +: 8] <= dat_q[8*b +: 8];
            end
         end
      end
   end

   // Transfer FSM. Ack and read data are registered on the ACK edge, so they are visible
   // in the cycle after ACK, during which the FSM is already back in IDLE; ack is
   // therefore one cycle wide and a held wb_cyc_i starts the next transfer from there.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         adr_q    <= 30'd0;
         dat_q    <= 32'd0;
         sel_q    <= 4'd0;
         we_q     <= 1'b0;
         wb_ack_o <= 1'b0;
         wb_rdt_o <= 32'd0;
         err_o    <= 1'b0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_rdt_o <= 32'd0;
         case (state)
            IDLE: begin
               if (wb_cyc_i) begin
                  adr_q    <= wb_adr_i;
                  dat_q    <= wb_dat_i;
                  sel_q    <= wb_sel_i;
                  we_q     <= wb_we_i;
                  wait_cnt <= 4'd0;
                  state    <= (WAIT_CYCLES > 0) ? WAIT : ACK;
               end
            end
            WAIT: begin
               if (!wb_cyc_i) begin
                  state <= IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= ACK;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            ACK: begin
               state    <= IDLE;
               wb_ack_o <= 1'b1;
               if (!we_q) begin
                  if (is_mbox) begin
                     wb_rdt_o <= {24'd0, done_code_o};
                  end else if (in_range) begin
                     wb_rdt_o <= mem[idx];
                  end
               end
               if (!in_range && !is_mbox) begin
                  err_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_RAM_MAILBOX_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         done_o      <= 1'b0;
         done_code_o <= 8'd0;
      end else if ((state == ACK) && we_q && is_mbox && sel_q[0]) begin
         done_code_o <= dat_q[7:0];
         if (dat_q == 32'h0000_00AD) begin
            done_o <= 1'b1;
         end
      end
   end
`else
   assign done_o      = 1'b0;
   assign done_code_o = 8'd0;
`endif

   // Saturating cycle counter, frozen once the end-of-test flag is raised.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cycle_cnt_o <= 32'd0;
      end else if (!done_o && (cycle_cnt_o != 32'hFFFF_FFFF)) begin
         cycle_cnt_o <= cycle_cnt_o + 32'd1;
      end
   end

endmodule

// File: doc/wb_ram_slave.md
WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning the number of 32-bit RAM words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the extra wait cycles between request capture and ack (range 0..15).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wb_adr_i  input  30  word address [31:2].
REQ-006 SHALL have port wb_dat_i  input  32  write data.
REQ-007 SHALL have port wb_sel_i  input  4  byte enables; bit n covers byte lane n.
REQ-008 SHALL have port wb_we_i  input  1  write when 1, read when 0.
REQ-009 SHALL have port wb_cyc_i  input  1  bus request.
REQ-010 SHALL have port wb_rdt_o  output  32  read data, valid in the wb_ack_o cycle.
REQ-011 SHALL have port wb_ack_o  output  1  one-cycle transfer acknowledge.
REQ-012 SHALL have port err_o  output  1  sticky out-of-range access flag.
REQ-013 SHALL have port cycle_cnt_o  output  32  clk cycles counted since reset release.
REQ-014 SHALL have port done_o  output  1  sticky end-of-test flag (mailbox build only).
REQ-015 SHALL have port done_code_o  output  8  last mailbox code (mailbox build only).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and ACK.
REQ-017 IDLE with wb_cyc_i=1 SHALL capture adr/dat/sel/we, then go to WAIT if WAIT_CYCLES>0, else to ACK.
REQ-018 WAIT SHALL count WAIT_CYCLES cycles, then go to ACK.
REQ-019 wb_cyc_i=0 during WAIT SHALL abort the transfer: return to IDLE, no write, no ack.
REQ-020 ACK SHALL assert wb_ack_o for exactly one cycle and return to IDLE.
REQ-021 In ACK, wb_ack_o SHALL be held low for at least one cycle before the next ack, so back-to-back requests cost WAIT_CYCLES+2 cycles each.
REQ-022 Latency from wb_cyc_i sampled high to wb_ack_o high SHALL be WAIT_CYCLES+1 cycles.
REQ-023 An in-range write SHALL update only the enabled byte lanes of mem[adr] on the ACK edge.
REQ-024 An in-range read SHALL drive wb_rdt_o = mem[adr] during ACK.
REQ-025 wb_rdt_o SHALL be 0 outside ACK.
REQ-026 A read-after-write to the same address SHALL return the new data.
REQ-027 adr>=DEPTH (not the mailbox) SHALL: still ack, ignore writes, read 0, and set err_o.
REQ-028 err_o SHALL stay set until reset.
REQ-029 wb_sel_i=0 on a write SHALL ack with no memory change.
REQ-030 cycle_cnt_o SHALL increment every cycle after reset release and saturate at 32'hFFFF_FFFF.
REQ-031 cycle_cnt_o SHALL freeze once done_o=1.

Reset
REQ-032 While resetn=0, outputs SHALL be: FSM=IDLE, wb_ack_o=0, wb_rdt_o=0, err_o=0, cycle_cnt_o=0, done_o=0, done_code_o=0.
REQ-033 RAM contents SHALL not be reset.
REQ-034 Reset asserted mid-transfer SHALL drop the pending transfer with no write and no ack.

Configuration
REQ-035 Macro WB_RAM_MAILBOX_EN defined SHALL decode word address 30'h0400_0001 as the mailbox:
- write with wb_sel_i[0]=1: done_code_o<=dat[7:0]; done_o<=1 if dat==32'h0000_00AD
- read: returns {24'b0, done_code_o}
- never sets err_o
REQ-036 Macro WB_RAM_MAILBOX_EN undefined SHALL:
- treat address 30'h0400_0001 as an ordinary out-of-range address
- tie done_o and done_code_o to 0

Verification
REQ-037 WAIT_CYCLES=1: write adr 5, data 32'h1234_5678, sel 4'hF; then read adr 5 -> ack 2 cycles after each cyc, read data 32'h1234_5678.
REQ-038 mem[7]=32'hFFFF_FFFF; write adr 7, sel 4'b0101, data 32'hAABB_CCDD -> read returns 32'hFFBB_FFDD.
REQ-039 Read adr DEPTH (4096) -> ack, wb_rdt_o=0, err_o=1 and still 1 after 100 cycles.
REQ-040 Drop wb_cyc_i in WAIT on a write to adr 3 with WAIT_CYCLES=3 -> no ack, mem[3] unchanged.
REQ-041 Mailbox build: write 32'h0000_00AD to adr 30'h0400_0001 -> done_o=1, done_code_o=8'hAD, cycle_cnt_o frozen.
REQ-042 Non-mailbox build: write 32'h0000_00AD to adr 30'h0400_0001 -> err_o=1, done_o=0.
